lat_bram: RTL and testbench
===========================

# lat_bram

Parametrised single-port block RAM with a programmable access latency and an EN/READY request handshake. It is the successor to the fixed 32-bit, 1024-word, 11-wait-state BRAM model. It generalises data width, depth and latency, and adds the following:
- Request capture, so inputs may change after acceptance.
- An out-of-range address error.
- A BUSY indication.
- Storage that is preserved across reset.

It sits behind the user-project bus adapter as the wait-stated backing memory for firmware and tap data.

## Interface
- `DW`, default 32: data width in bits; a multiple of 8.
- `DEPTH`, default 1024: number of words; any value ≥ 2, power of two not required.
- `AW`, default 32: address port width.
- `LATENCY`, default 11: wait cycles per access; ≥ 1.
- `NB`, default DW/8 (derived): number of byte lanes.
- `CLK` in 1: clock; all logic on the rising edge.
- `RSTN` in 1: reset, synchronous, active-low.
- `EN` in 1: request valid.
- `WE` in NB: byte-lane write enables; all zero means read.
- `A` in AW: word address; bits above clog2(DEPTH) are range-checked, not truncated.
- `Di` in DW: write data.
- `Do` out DW: read data; registered.
- `READY` out 1: one-cycle completion pulse.
- `ERR` out 1: valid only with READY; the address was ≥ DEPTH.
- `BUSY` out 1: high from acceptance until READY deasserts.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If EN=1 at the edge, capture A, WE, Di into registers.
  - Load the wait counter with LATENCY-1, set BUSY, go to WAIT.
  - If EN=0, stay in IDLE.
- WAIT:
  - While the counter is non-zero, decrement it.
  - When the counter is 0 at the edge, perform the access from the captured values and go to DONE.
  - For an in-range address: Do <= the old word (read-before-write), then write each lane i whose WE[i]=1 with Di[8i+7:8i]. ERR <= 0.
  - For an out-of-range address: no write; Do <= 0; ERR <= 1.
  - READY <= 1.
- DONE:
  - READY=1 for exactly this one cycle. EN is ignored in this cycle, since the requester is still holding it.
  - At the next edge: READY <= 0, ERR <= 0, BUSY <= 0, go to IDLE.
- Do holds the last access result until the next access completes; it is not zeroed when idle.
- EN, A, WE and Di are don't-care after acceptance. Changes during WAIT or DONE have no effect.
- Reset (RSTN=0 at an edge), from any state:
  - State goes to IDLE; counter and captured registers are cleared.
  - Do=0, READY=0, ERR=0, BUSY=0.
  - An in-flight access is aborted with no write.
  - RAM contents are NOT cleared, so the array infers as block RAM.

## Timing
- Acceptance at edge t0 (IDLE, EN=1).
- Access and READY/Do/ERR update occur at edge t0+LATENCY. READY is visible in the cycle after that edge.
- BUSY is high in the cycles after edges t0 through t0+LATENCY.
- Minimum request spacing is LATENCY+2 edges. EN held continuously gives one access per LATENCY+2 cycles.
- Example, LATENCY=1: accept at edge 0, READY high after edge 1, IDLE after edge 2, next acceptance at edge 3.
- Reset asserted during WAIT at edge t: READY never pulses for that request. The first acceptance is possible at the first edge with RSTN=1 and EN=1.

## Structure
- Package `lat_bram_pkg`:
  - State enum {IDLE, WAIT, DONE}.
  - A function computing the counter width, clog2(LATENCY) with a minimum of 1.
  - A function computing the index width, clog2(DEPTH).
- Sub-module `bram_core` (parameters DW, DEPTH):
  - Pure byte-enabled single-port synchronous array with read-before-write.
  - Ports: CLK, en, we[NB-1:0], idx, din, dout.
  - No reset.
- `lat_bram` contains the FSM, counter, capture registers, range check and output registers.

## Test plan
1. Reset with LATENCY=11, then read address 5: READY is high exactly 11 edges after acceptance, Do=0, ERR=0, BUSY high for 12 cycles.
2. Partial write:
   - Write 0xAABBCCDD to address 3 with WE=4'b1111.
   - Then write 0x11223344 with WE=4'b0101.
   - Then read: the second access returns Do=0xAABBCCDD; the read returns 0xAA22CC44.
3. Out-of-range access, DEPTH=1000:
   - Write address 1000 with 0xFFFFFFFF, then read address 1000: both give ERR=1 with READY and Do=0.
   - Then read address 999: returns its prior value with ERR=0.
4. EN held high with LATENCY=1 for 9 cycles: exactly 3 READY pulses, each 3 cycles apart.
5. Address and data change during WAIT:
   - Accept a write to address 7 with 0x12345678, then drive A=8, Di=0 until READY.
   - Address 7 then reads back 0x12345678, and address 8 is unchanged.
6. Reset during WAIT:
   - Write 0xDEADBEEF to address 2, then assert RSTN=0 at cycle 4 of the wait.
   - Expected: no READY, all outputs 0, and a subsequent read of address 2 returns its pre-write value.
   - Data written before the reset still reads back unchanged, confirming storage survives reset.

Source files
------------

// File: rtl/lat_bram_pkg.sv
// Shared types and width helpers for the wait-stated block RAM.
package lat_bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wait-counter width: enough to hold LATENCY-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

  // Array index width for DEPTH words, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/bram_core.sv
// Byte-enabled single-port synchronous array, read-before-write, no reset.
module bram_core
  import lat_bram_pkg::*;
#(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned NB    = DW / 8,
  localparam int unsigned IW    = idx_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          en,
  input  logic [NB-1:0] we,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  // Return the old word and update the enabled byte lanes in the same edge.
  always_ff @(posedge CLK) begin
    if (en) begin
      dout <= mem[idx];
      for (int i = 0; i < int'(NB); i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/lat_bram.sv
// Single-port block RAM with programmable access latency and EN/READY handshake.
module lat_bram
  import lat_bram_pkg::*;
#(
  parameter  int unsigned DW      = 32,
  parameter  int unsigned DEPTH   = 1024,
  parameter  int unsigned AW      = 32,
  parameter  int unsigned LATENCY = 11,
  localparam int unsigned NB      = DW / 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          EN,
  input  logic [NB-1:0] WE,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Di,
  output logic [DW-1:0] Do,
  output logic          READY,
  output logic          ERR,
  output logic          BUSY
);

  localparam int unsigned CW = cnt_width(LATENCY);
  localparam int unsigned IW = idx_width(DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] a_q;
  logic [NB-1:0] we_q;
  logic [DW-1:0] di_q;
  logic          rd_ok_q;
  logic [DW-1:0] core_dout;

  logic in_range_c;
  logic core_en_c;

  // Range check on the full captured address; the array fires only on the access edge.
  assign in_range_c = ({1'b0, a_q} < DEPTH_X);
  assign core_en_c  = RSTN && (state == WAIT) && (cnt == '0) && in_range_c;

  bram_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_core (
    .CLK  (CLK),
    .en   (core_en_c),
    .we   (we_q),
    .idx  (a_q[IW-1:0]),
    .din  (di_q),
    .dout (core_dout)
  );

  // Array output register is unreset; gate it to zero after reset or an error access.
  assign Do = rd_ok_q ? core_dout : '0;

  // Request FSM: capture, count down wait states, pulse READY for one cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      we_q    <= '0;
      di_q    <= '0;
      rd_ok_q <= 1'b0;
      READY   <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EN) begin
            a_q   <= A;
            we_q  <= WE;
            di_q  <= Di;
            cnt   <= CNT_LOAD;
            BUSY  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            READY   <= 1'b1;
            ERR     <= !in_range_c;
            rd_ok_q <= in_range_c;
            state   <= DONE;
          end
        end
        DONE: begin
          READY <= 1'b0;
          ERR   <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lat_bram.sv
// Directed self-checking bench for lat_bram.
module tb_lat_bram;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en0, en1;
  logic [3:0]  we0, we1;
  logic [31:0] a0, a1, di0, di1, do0, do1;
  logic        rdy0, rdy1, err0, err1, busy0, busy1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  lat_bram #(.DW(32), .DEPTH(1000), .AW(32), .LATENCY(11)) dut0 (
    .CLK(clk), .RSTN(rstn), .EN(en0), .WE(we0), .A(a0), .Di(di0),
    .Do(do0), .READY(rdy0), .ERR(err0), .BUSY(busy0)
  );

  lat_bram #(.DW(32), .DEPTH(16), .AW(32), .LATENCY(1)) dut1 (
    .CLK(clk), .RSTN(rstn), .EN(en1), .WE(we1), .A(a1), .Di(di1),
    .Do(do1), .READY(rdy1), .ERR(err1), .BUSY(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on dut0; inputs are scrambled right after acceptance.
  task automatic acc0(input string tag, input logic [31:0] addr, input logic [3:0] we,
                      input logic [31:0] di, input bit chk_do, input logic [31:0] exp_do,
                      input logic exp_err);
    int n;
    int nb;
    @(negedge clk);
    en0 = 1'b1; a0 = addr; we0 = we; di0 = di;
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0; a0 = addr + 32'd1; di0 = 32'd0; we0 = 4'h0;
    n  = 0;
    nb = busy0 ? 1 : 0;
    while (rdy0 !== 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (busy0) nb++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd11);
    chk({tag, "_busy"}, 32'(nb), 32'd12);
    chk({tag, "_err"}, {31'd0, err0}, {31'd0, exp_err});
    if (chk_do) chk({tag, "_do"}, do0, exp_do);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {29'd0, rdy0, err0, busy0}, 32'd0);
  endtask

  initial begin
    int npulse;
    int last;
    bit seen;

    rstn = 1'b0;
    en0 = 1'b0; we0 = '0; a0 = '0; di0 = '0;
    en1 = 1'b0; we1 = '0; a1 = '0; di1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do", do0, 32'd0);
    chk("rst_flags", {29'd0, rdy0, err0, busy0}, 32'd0);
    chk("rst_flags1", {29'd0, rdy1, err1, busy1}, 32'd0);
    rstn = 1'b1;

    // Give the words used below known contents.
    acc0("init2",   32'd2,   4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
    acc0("init3",   32'd3,   4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
    acc0("init5",   32'd5,   4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
    acc0("init7",   32'd7,   4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
    acc0("init8",   32'd8,   4'hF, 32'd0, 1'b0, 32'd0, 1'b0);
    acc0("init999", 32'd999, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0);

    // Plain read with full latency and BUSY window.
    acc0("t1_rd5", 32'd5, 4'h0, 32'd0, 1'b1, 32'd0, 1'b0);

    // Partial write and read-before-write.
    acc0("t2_wr_full", 32'd3, 4'hF, 32'hAABBCCDD, 1'b1, 32'd0,        1'b0);
    acc0("t2_wr_part", 32'd3, 4'h5, 32'h11223344, 1'b1, 32'hAABBCCDD, 1'b0);
    acc0("t2_rd",      32'd3, 4'h0, 32'd0,        1'b1, 32'hAA22CC44, 1'b0);

    // Out-of-range accesses.
    acc0("t3_wr_oor", 32'd1000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1);
    acc0("t3_rd_oor", 32'd1000, 4'h0, 32'd0,        1'b1, 32'd0, 1'b1);
    acc0("t3_rd999",  32'd999,  4'h0, 32'd0,        1'b1, 32'd0, 1'b0);

    // Inputs change during WAIT (acc0 drives A=addr+1, Di=0 after acceptance).
    acc0("t5_wr7", 32'd7, 4'hF, 32'h12345678, 1'b1, 32'd0,        1'b0);
    acc0("t5_rd7", 32'd7, 4'h0, 32'd0,        1'b1, 32'h12345678, 1'b0);
    acc0("t5_rd8", 32'd8, 4'h0, 32'd0,        1'b1, 32'd0,        1'b0);

    // EN held with LATENCY=1: a READY pulse every 3 cycles.
    @(negedge clk);
    en1 = 1'b1; a1 = 32'd1; we1 = 4'h0;
    npulse = 0;
    last   = -1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy1 === 1'b1) begin
        if (last >= 0) chk("t4_spacing", 32'(k - last), 32'd3);
        last = k;
        npulse++;
      end
    end
    en1 = 1'b0;
    chk("t4_pulses", 32'(npulse), 32'd3);
    chk("t4_last", 32'(last), 32'd8);

    // Reset during WAIT aborts the write.
    @(negedge clk);
    en0 = 1'b1; a0 = 32'd2; we0 = 4'hF; di0 = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    en0 = 1'b0; we0 = 4'h0; di0 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_do", do0, 32'd0);
    chk("t6_rst_flags", {29'd0, rdy0, err0, busy0}, 32'd0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy0 === 1'b1) seen = 1'b1;
    end
    chk("t6_no_ready", {31'd0, seen}, 32'd0);
    acc0("t6_rd2", 32'd2, 4'h0, 32'd0, 1'b1, 32'd0,        1'b0);
    acc0("t6_rd3", 32'd3, 4'h0, 32'd0, 1'b1, 32'hAA22CC44, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
